// File: rtl/mc_stage_ctrl_if.sv
// Instruction/data SRAM request-ack handshake between the stage controller and the memory ports.
// The controller drives the master side; the SRAM model or arbiter sits on the slave side.
interface mc_stage_ctrl_if;
    logic inst_req;
    logic inst_ack;
    logic data_req;
    logic data_we;
    logic data_ack;

    modport master (
        output inst_req,
        output data_req,
        output data_we,
        input  inst_ack,
        input  data_ack
    );

    modport slave (
        input  inst_req,
        input  data_req,
        input  data_we,
        output inst_ack,
        output data_ack
    );
endinterface

// File: rtl/mc_stage_ctrl.sv
// Multi-cycle IF/ID/EXE/MEM/WB sequencer for the shared-datapath core.
// It also provides a per-request ack watchdog and a retired-instruction counter.
module mc_stage_ctrl #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 32
) (
    input  logic               clk,
    input  logic               reset,
    mc_stage_ctrl_if.master    mem,
    input  logic               dec_load,
    input  logic               dec_store,
    input  logic               dec_gr_we,
    input  logic               br_taken,
    output logic [2:0]         state,
    output logic               ir_we,
    output logic               alu_we,
    output logic               mdr_we,
    output logic               rf_we,
    output logic               pc_we,
    output logic               pc_sel_br,
    output logic               retire,
    output logic [CNT_W-1:0]   retire_cnt,
    output logic               err
);

    localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EXE  = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd7
    } state_e;

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]   retire_cnt_q, retire_cnt_d;
    logic               err_q, err_d;

    logic inst_req_s, data_req_s, data_we_s;
    logic timeout;
    logic wait_expired;

    assign wait_expired = (MAX_WAIT != 0) && (wait_cnt_q == WAIT_LAST);

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = '0;
        timeout      = 1'b0;
        inst_req_s   = 1'b0;
        data_req_s   = 1'b0;
        data_we_s    = 1'b0;
        ir_we        = 1'b0;
        alu_we       = 1'b0;
        mdr_we       = 1'b0;
        rf_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel_br    = 1'b0;
        retire       = 1'b0;

        case (state_q)
            S_IF: begin
                inst_req_s = 1'b1;
                if (mem.inst_ack) begin
                    ir_we   = 1'b1;
                    state_d = S_ID;
                end else if (wait_expired) begin
                    timeout = 1'b1;
                    state_d = S_HALT;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            S_ID: begin
                state_d = S_EXE;
            end
            S_EXE: begin
                alu_we = 1'b1;
                if (dec_load || dec_store) begin
                    state_d = S_MEM;
                end else if (dec_gr_we) begin
                    state_d = S_WB;
                end else begin
                    pc_we     = 1'b1;
                    retire    = 1'b1;
                    pc_sel_br = br_taken;
                    state_d   = S_IF;
                end
            end
            S_MEM: begin
                data_req_s = 1'b1;
                data_we_s  = dec_store;
                if (mem.data_ack) begin
                    if (dec_store) begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = S_IF;
                    end else begin
                        mdr_we  = 1'b1;
                        state_d = S_WB;
                    end
                end else if (wait_expired) begin
                    timeout = 1'b1;
                    state_d = S_HALT;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            S_WB: begin
                rf_we     = dec_gr_we;
                pc_we     = 1'b1;
                retire    = 1'b1;
                pc_sel_br = br_taken;
                state_d   = S_IF;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IF;
            end
        endcase

        // Strobes must never fire in a reset cycle, whatever state is being abandoned.
        if (reset) begin
            inst_req_s = 1'b0;
            data_req_s = 1'b0;
            data_we_s  = 1'b0;
            ir_we      = 1'b0;
            alu_we     = 1'b0;
            mdr_we     = 1'b0;
            rf_we      = 1'b0;
            pc_we      = 1'b0;
            pc_sel_br  = 1'b0;
            retire     = 1'b0;
            timeout    = 1'b0;
        end

        retire_cnt_d = retire ? (retire_cnt_q + CNT_W'(1)) : retire_cnt_q;
        err_d        = err_q | timeout;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IF;
            wait_cnt_q   <= '0;
            retire_cnt_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            retire_cnt_q <= retire_cnt_d;
            err_q        <= err_d;
        end
    end

    assign mem.inst_req = inst_req_s;
    assign mem.data_req = data_req_s;
    assign mem.data_we  = data_we_s;
    assign state        = state_q;
    assign retire_cnt   = retire_cnt_q;
    assign err          = err_q;

endmodule

// File: tb/tb_mc_stage_ctrl.sv
// Bench for mc_stage_ctrl: each instruction is expanded into its expected per-cycle stage trace
// from the instruction class and random ack delays, then replayed against the DUT.
module tb_mc_stage_ctrl;

    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 8;

    typedef enum int {K_ALU, K_BR, K_LOAD, K_STORE, K_JL} kind_e;

    typedef struct {
        logic [2:0] st;
        logic [9:0] strb;
        logic       iack;
        logic       dack;
    } cyc_t;

    logic             clk;
    logic             reset;
    logic             dec_load, dec_store, dec_gr_we, br_taken;
    logic [2:0]       state;
    logic             ir_we, alu_we, mdr_we, rf_we, pc_we, pc_sel_br, retire, err;
    logic [CNT_W-1:0] retire_cnt;
    logic [9:0]       obs_strb;

    int   n_checks;
    int   n_fail;
    int   model_cnt;
    cyc_t exp_q[$];

    mc_stage_ctrl_if bus ();

    mc_stage_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem        (bus),
        .dec_load   (dec_load),
        .dec_store  (dec_store),
        .dec_gr_we  (dec_gr_we),
        .br_taken   (br_taken),
        .state      (state),
        .ir_we      (ir_we),
        .alu_we     (alu_we),
        .mdr_we     (mdr_we),
        .rf_we      (rf_we),
        .pc_we      (pc_we),
        .pc_sel_br  (pc_sel_br),
        .retire     (retire),
        .retire_cnt (retire_cnt),
        .err        (err)
    );

    // Bit order: inst_req ir_we alu_we data_req data_we mdr_we rf_we pc_we pc_sel_br retire
    assign obs_strb = {bus.inst_req, ir_we, alu_we, bus.data_req, bus.data_we,
                       mdr_we, rf_we, pc_we, pc_sel_br, retire};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    function automatic logic [9:0] mk(input logic ireq, input logic irw, input logic alu,
                                      input logic dreq, input logic dwe, input logic mdr,
                                      input logic rf, input logic pc, input logic sel,
                                      input logic ret);
        return {ireq, irw, alu, dreq, dwe, mdr, rf, pc, sel, ret};
    endfunction

    function automatic logic rnd_bit();
        return logic'($urandom_range(0, 1));
    endfunction

    function automatic void push(input logic [2:0] st, input logic [9:0] strb,
                                 input logic ia, input logic da);
        cyc_t c;
        c.st = st; c.strb = strb; c.iack = ia; c.dack = da;
        exp_q.push_back(c);
    endfunction

    // Expected stage trace of one instruction from its class and the requested ack delays.
    function automatic void build_instr(input kind_e k, input logic br, input int wi, input int wd);
        logic is_st, is_mem, gr;
        is_st  = (k == K_STORE);
        is_mem = (k == K_LOAD) || (k == K_STORE);
        gr     = (k == K_ALU) || (k == K_LOAD) || (k == K_JL);
        for (int i = 0; i < wi; i++) push(3'd0, mk(1,0,0,0,0,0,0,0,0,0), 1'b0, rnd_bit());
        push(3'd0, mk(1,1,0,0,0,0,0,0,0,0), 1'b1, rnd_bit());
        push(3'd1, mk(0,0,0,0,0,0,0,0,0,0), rnd_bit(), rnd_bit());
        if (k == K_BR)
            push(3'd2, mk(0,0,1,0,0,0,0,1,br,1), rnd_bit(), rnd_bit());
        else
            push(3'd2, mk(0,0,1,0,0,0,0,0,0,0), rnd_bit(), rnd_bit());
        if (is_mem) begin
            for (int i = 0; i < wd; i++) push(3'd3, mk(0,0,0,1,is_st,0,0,0,0,0), rnd_bit(), 1'b0);
            if (is_st) push(3'd3, mk(0,0,0,1,1,0,0,1,0,1), rnd_bit(), 1'b1);
            else       push(3'd3, mk(0,0,0,1,0,1,0,0,0,0), rnd_bit(), 1'b1);
        end
        if (k != K_BR && k != K_STORE)
            push(3'd4, mk(0,0,0,0,0,0,gr,1,br,1), rnd_bit(), rnd_bit());
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; bus.inst_ack = 1'b0; bus.data_ack = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        model_cnt = 0;
    endtask

    task automatic run_instr(input kind_e k, input logic br, input int wi, input int wd);
        cyc_t c;
        logic [CNT_W-1:0] exp_cnt;
        int n;
        n = 0;
        exp_q.delete();
        build_instr(k, br, wi, wd);
        while (exp_q.size() > 0) begin
            c = exp_q.pop_front();
            @(negedge clk);
            dec_load     = (k == K_LOAD);
            dec_store    = (k == K_STORE);
            dec_gr_we    = (k == K_ALU) || (k == K_LOAD) || (k == K_JL);
            br_taken     = br;
            bus.inst_ack = c.iack;
            bus.data_ack = c.dack;
            #1;
            exp_cnt = CNT_W'(model_cnt);
            n_checks++;
            if (state !== c.st) begin
                n_fail++;
                $display("[TB] FAIL state kind=%0d cyc=%0d: got %0d want %0d", k, n, state, c.st);
            end
            n_checks++;
            if (obs_strb !== c.strb) begin
                n_fail++;
                $display("[TB] FAIL strobes kind=%0d cyc=%0d: got %b want %b", k, n, obs_strb, c.strb);
            end
            n_checks++;
            if (retire_cnt !== exp_cnt) begin
                n_fail++;
                $display("[TB] FAIL retire_cnt kind=%0d cyc=%0d: got %0d want %0d", k, n, retire_cnt, exp_cnt);
            end
            n_checks++;
            if (err !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL err kind=%0d cyc=%0d: got %b want 0", k, n, err);
            end
            if (c.strb[0]) model_cnt++;
            n++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; bus.inst_ack = 1'b1; bus.data_ack = 1'b1;
        dec_load = 1'b1; dec_store = 1'b1; dec_gr_we = 1'b1; br_taken = 1'b1;
        #1;
        n_checks++;
        if (obs_strb !== 10'b0) begin
            n_fail++; $display("[TB] FAIL reset_strobes: got %b want 0", obs_strb);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (state !== 3'd0 || retire_cnt !== '0 || err !== 1'b0 || obs_strb !== 10'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_values: state=%0d cnt=%0d err=%b strb=%b want 0/0/0/0",
                     state, retire_cnt, err, obs_strb);
        end
        reset = 1'b0; bus.inst_ack = 1'b0;
        #1;
        n_checks++;
        if (state !== 3'd0 || bus.inst_req !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL first_if: state=%0d inst_req=%b want 0/1", state, bus.inst_req);
        end
    endtask

    task automatic test_directed_mix();
        do_reset();
        run_instr(K_ALU, 1'b0, 0, 0);
        n_checks++;
        if (model_cnt != 1) begin
            n_fail++; $display("[TB] FAIL add_model_cnt: got %0d want 1", model_cnt);
        end
        run_instr(K_LOAD, 1'b0, 0, 3);
        run_instr(K_BR, 1'b1, 0, 0);
        run_instr(K_STORE, 1'b0, 0, 0);
        run_instr(K_JL, 1'b1, 2, 0);
    endtask

    task automatic test_random();
        kind_e k;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            k = kind_e'($urandom_range(0, 4));
            run_instr(k, (k == K_JL) ? 1'b1 : rnd_bit(), $urandom_range(0, 3), $urandom_range(0, 3));
        end
    endtask

    task automatic test_watchdog();
        do_reset();
        for (int i = 0; i < MAX_WAIT; i++) begin
            @(negedge clk); bus.inst_ack = 1'b0; #1;
            n_checks++;
            if (state !== 3'd0 || bus.inst_req !== 1'b1) begin
                n_fail++; $display("[TB] FAIL wd_if_wait%0d: state=%0d inst_req=%b want 0/1", i, state, bus.inst_req);
            end
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); bus.inst_ack = 1'b1; bus.data_ack = 1'b1; #1;
            n_checks++;
            if (state !== 3'd7 || err !== 1'b1 || obs_strb !== 10'b0) begin
                n_fail++;
                $display("[TB] FAIL wd_halt%0d: state=%0d err=%b strb=%b want 7/1/0", i, state, err, obs_strb);
            end
        end
        do_reset();
        for (int i = 0; i < MAX_WAIT - 1; i++) begin
            @(negedge clk); bus.inst_ack = 1'b0;
        end
        @(negedge clk); bus.inst_ack = 1'b1; #1;
        n_checks++;
        if (ir_we !== 1'b1 || state !== 3'd0) begin
            n_fail++; $display("[TB] FAIL wd_last_ack: ir_we=%b state=%0d want 1/0", ir_we, state);
        end
        @(negedge clk); bus.inst_ack = 1'b0; #1;
        n_checks++;
        if (state !== 3'd1 || err !== 1'b0) begin
            n_fail++; $display("[TB] FAIL wd_last_ack_id: state=%0d err=%b want 1/0", state, err);
        end
        // Data-side watchdog: a store whose ack never comes.
        do_reset();
        dec_load = 1'b0; dec_store = 1'b1; dec_gr_we = 1'b0; br_taken = 1'b0;
        @(negedge clk); bus.inst_ack = 1'b1; bus.data_ack = 1'b0;
        @(negedge clk); bus.inst_ack = 1'b0;
        @(negedge clk);
        for (int i = 0; i < MAX_WAIT; i++) begin
            @(negedge clk); #1;
            n_checks++;
            if (state !== 3'd3 || bus.data_req !== 1'b1 || bus.data_we !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL wd_mem_wait%0d: state=%0d req=%b we=%b want 3/1/1", i, state, bus.data_req, bus.data_we);
            end
        end
        @(negedge clk); bus.data_ack = 1'b1; #1;
        n_checks++;
        if (state !== 3'd7 || err !== 1'b1 || obs_strb !== 10'b0) begin
            n_fail++; $display("[TB] FAIL wd_mem_halt: state=%0d err=%b strb=%b want 7/1/0", state, err, obs_strb);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        run_instr(K_ALU, 1'b0, 0, 0);
        dec_load = 1'b1; dec_store = 1'b0; dec_gr_we = 1'b1; br_taken = 1'b0;
        @(negedge clk); bus.inst_ack = 1'b1; bus.data_ack = 1'b0;
        @(negedge clk); bus.inst_ack = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        n_checks++;
        if (state !== 3'd3 || bus.data_req !== 1'b1 || retire_cnt !== CNT_W'(1)) begin
            n_fail++;
            $display("[TB] FAIL mid_mem: state=%0d req=%b cnt=%0d want 3/1/1", state, bus.data_req, retire_cnt);
        end
        @(negedge clk); reset = 1'b1; #1;
        n_checks++;
        if (bus.data_req !== 1'b0 || obs_strb !== 10'b0) begin
            n_fail++; $display("[TB] FAIL mid_reset_strobes: req=%b strb=%b want 0/0", bus.data_req, obs_strb);
        end
        @(negedge clk); reset = 1'b0; #1;
        n_checks++;
        if (state !== 3'd0 || retire_cnt !== '0 || err !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL mid_after: state=%0d cnt=%0d err=%b want 0/0/0", state, retire_cnt, err);
        end
    endtask

    task automatic test_back_to_back();
        logic [CNT_W-1:0] want;
        want = CNT_W'(1000 % 256);
        do_reset();
        for (int i = 0; i < 1000; i++) run_instr(K_ALU, 1'b0, 0, 0);
        @(negedge clk); bus.inst_ack = 1'b0; #1;
        n_checks++;
        if (retire_cnt !== want) begin
            n_fail++; $display("[TB] FAIL b2b_count: got %0d want %0d", retire_cnt, want);
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0; model_cnt = 0;
        reset = 1'b1;
        bus.inst_ack = 1'b0; bus.data_ack = 1'b0;
        dec_load = 1'b0; dec_store = 1'b0; dec_gr_we = 1'b0; br_taken = 1'b0;
        test_reset();
        test_directed_mix();
        test_random();
        test_watchdog();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
